// File: rtl/decode_pipe_if.sv
// Decode-stage bus: fetch/writeback inputs into decode_pipe and the ID/EX register outputs.
// master is the fetch/writeback side, slave is the decode stage itself.
interface decode_pipe_if #(
   parameter int DATA_W = 32
);
   logic              in_valid;
   logic [31:0]       instruction;
   logic              flush;
   logic              reg_write;
   logic [4:0]        write_reg;
   logic [DATA_W-1:0] write_data;

   logic              stall_out;
   logic              out_valid;
   logic [5:0]        op_code;
   logic [5:0]        funct;
   logic [4:0]        rs;
   logic [4:0]        rt;
   logic [4:0]        rd;
   logic [DATA_W-1:0] read_data1;
   logic [DATA_W-1:0] read_data2;
   logic [DATA_W-1:0] sign_ext_imm;
   logic              mem_read;

   modport master (
      output in_valid, instruction, flush, reg_write, write_reg, write_data,
      input  stall_out, out_valid, op_code, funct, rs, rt, rd,
             read_data1, read_data2, sign_ext_imm, mem_read
   );

   modport slave (
      input  in_valid, instruction, flush, reg_write, write_reg, write_data,
      output stall_out, out_valid, op_code, funct, rs, rt, rd,
             read_data1, read_data2, sign_ext_imm, mem_read
   );
endinterface

// File: rtl/decode_pipe.sv
// MIPS instruction decode stage: register file with write-first bypass, sign extension,
// load-use hazard detection and the ID/EX pipeline register.
module decode_pipe #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32
) (
   input logic         clk,
   input logic         rst,
   decode_pipe_if.slave bus
);
   localparam int         ADDR_W = $clog2(NUM_REGS);
   localparam logic [5:0] OP_LW  = 6'b100011;

   logic [DATA_W-1:0] regFile [NUM_REGS];
   logic [ADDR_W-1:0] wrIdx;
   logic [ADDR_W-1:0] rsIdx;
   logic [ADDR_W-1:0] rtIdx;
   logic              wrEn;
   logic [DATA_W-1:0] rsData;
   logic [DATA_W-1:0] rtData;
   logic [DATA_W-1:0] immExt;
   logic              hazard;
   logic              stall;
   logic              accept;

   logic              outValid;
   logic              memRead;
   logic [5:0]        opCode;
   logic [5:0]        functReg;
   logic [4:0]        rsReg;
   logic [4:0]        rtReg;
   logic [4:0]        rdReg;
   logic [DATA_W-1:0] readData1;
   logic [DATA_W-1:0] readData2;
   logic [DATA_W-1:0] signExtImm;

   assign wrIdx = bus.write_reg[ADDR_W-1:0];
   assign rsIdx = bus.instruction[21 +: ADDR_W];
   assign rtIdx = bus.instruction[16 +: ADDR_W];
   assign wrEn  = bus.reg_write && (wrIdx != '0);

   // Write-first: a same-cycle writeback to the index being read wins over the stored value.
   function automatic logic [DATA_W-1:0] readPort(input logic [ADDR_W-1:0] idx);
      if (idx == '0)
         return '0;
      else if (wrEn && (wrIdx == idx))
         return bus.write_data;
      else
         return regFile[idx];
   endfunction

   always_comb begin
      rsData = readPort(rsIdx);
      rtData = readPort(rtIdx);
   end

   assign immExt = DATA_W'($signed(bus.instruction[15:0]));

   assign hazard = outValid && memRead && (rtReg != 5'd0) &&
                   ((rtReg == bus.instruction[25:21]) || (rtReg == bus.instruction[20:16]));
   assign stall  = bus.in_valid && hazard && !bus.flush;
   assign accept = bus.in_valid && !stall && !bus.flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++)
            regFile[i] <= '0;
      end else if (wrEn) begin
         regFile[wrIdx] <= bus.write_data;
      end
   end

   // A bubble zeroes every ID/EX field, so mem_read drops and a stall never repeats.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outValid   <= 1'b0;
         memRead    <= 1'b0;
         opCode     <= '0;
         functReg   <= '0;
         rsReg      <= '0;
         rtReg      <= '0;
         rdReg      <= '0;
         readData1  <= '0;
         readData2  <= '0;
         signExtImm <= '0;
      end else if (accept) begin
         outValid   <= 1'b1;
         memRead    <= (bus.instruction[31:26] == OP_LW);
         opCode     <= bus.instruction[31:26];
         functReg   <= bus.instruction[5:0];
         rsReg      <= bus.instruction[25:21];
         rtReg      <= bus.instruction[20:16];
         rdReg      <= bus.instruction[15:11];
         readData1  <= rsData;
         readData2  <= rtData;
         signExtImm <= immExt;
      end else begin
         outValid   <= 1'b0;
         memRead    <= 1'b0;
         opCode     <= '0;
         functReg   <= '0;
         rsReg      <= '0;
         rtReg      <= '0;
         rdReg      <= '0;
         readData1  <= '0;
         readData2  <= '0;
         signExtImm <= '0;
      end
   end

   assign bus.stall_out    = stall;
   assign bus.out_valid    = outValid;
   assign bus.mem_read     = memRead;
   assign bus.op_code      = opCode;
   assign bus.funct        = functReg;
   assign bus.rs           = rsReg;
   assign bus.rt           = rtReg;
   assign bus.rd           = rdReg;
   assign bus.read_data1   = readData1;
   assign bus.read_data2   = readData2;
   assign bus.sign_ext_imm = signExtImm;
endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: table of vectors through a scoreboard queue, then hand sequences
// for load-use stall, flush, async reset and a small 8x16 configuration.
module tb_decode_pipe;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   decode_pipe_if #(.DATA_W(32)) bus ();
   decode_pipe_if #(.DATA_W(16)) bus16 ();

   decode_pipe #(.DATA_W(32), .NUM_REGS(32)) dut (.clk(clk), .rst(rst), .bus(bus));
   decode_pipe #(.DATA_W(16), .NUM_REGS(8))  dut16 (.clk(clk), .rst(rst), .bus(bus16));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [31:0] instr;
      logic        wr;
      logic [4:0]  wReg;
      logic [31:0] wData;
      logic [5:0]  op;
      logic [5:0]  funct;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic        memRead;
   } vec_t;

   vec_t vecs[8];
   vec_t sbq[$];

   function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rsF,
                                      input logic [4:0] rtF, input logic [15:0] imm);
      return {op, rsF, rtF, imm};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic edgeAndSettle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] instr, input logic fl,
                        input logic wr, input logic [4:0] wReg, input logic [31:0] wData);
      bus.in_valid    = v;
      bus.instruction = instr;
      bus.flush       = fl;
      bus.reg_write   = wr;
      bus.write_reg   = wReg;
      bus.write_data  = wData;
   endtask

   initial begin
      vec_t e;
      checks = 0;
      errors = 0;

      rst = 1'b1;
      drive(1'b1, 32'h04430004, 1'b0, 1'b0, 5'd0, 32'h0);
      bus16.in_valid    = 1'b0;
      bus16.instruction = '0;
      bus16.flush       = 1'b0;
      bus16.reg_write   = 1'b0;
      bus16.write_reg   = '0;
      bus16.write_data  = '0;

      //           instr                          wr    wReg   wData         op     funct   rs     rt     rd     rd1           rd2           imm           memRead
      vecs[0] = '{32'h04430004,                   1'b0, 5'd0,  32'h0,        6'h01, 6'h04, 5'd2,  5'd3,  5'd0,  32'h0,        32'h0,        32'h00000004, 1'b0};
      vecs[1] = '{mk(6'h00, 5'd5, 5'd6, 16'h3820), 1'b1, 5'd5,  32'hDEADBEEF, 6'h00, 6'h20, 5'd5,  5'd6,  5'd7,  32'hDEADBEEF, 32'h0,        32'h00003820, 1'b0};
      vecs[2] = '{mk(6'h0D, 5'd0, 5'd5, 16'h8000), 1'b1, 5'd0,  32'h12345678, 6'h0D, 6'h00, 5'd0,  5'd5,  5'd16, 32'h0,        32'hDEADBEEF, 32'hFFFF8000, 1'b0};
      vecs[3] = '{mk(6'h08, 5'd5, 5'd0, 16'h7FFF), 1'b1, 5'd1,  32'hA5A5A5A5, 6'h08, 6'h3F, 5'd5,  5'd0,  5'd15, 32'hDEADBEEF, 32'h0,        32'h00007FFF, 1'b0};
      vecs[4] = '{mk(6'h00, 5'd1, 5'd5, 16'h1234), 1'b1, 5'd5,  32'h11112222, 6'h00, 6'h34, 5'd1,  5'd5,  5'd2,  32'hA5A5A5A5, 32'h11112222, 32'h00001234, 1'b0};
      vecs[5] = '{mk(6'h23, 5'd1, 5'd0, 16'h0010), 1'b0, 5'd0,  32'h0,        6'h23, 6'h10, 5'd1,  5'd0,  5'd0,  32'hA5A5A5A5, 32'h0,        32'h00000010, 1'b1};
      vecs[6] = '{32'h00000000,                   1'b1, 5'd2,  32'h0000BEEF, 6'h00, 6'h00, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        1'b0};
      vecs[7] = '{mk(6'h2B, 5'd2, 5'd1, 16'hFFFC), 1'b0, 5'd0,  32'h0,        6'h2B, 6'h3C, 5'd2,  5'd1,  5'd31, 32'h0000BEEF, 32'hA5A5A5A5, 32'hFFFFFFFC, 1'b0};

      // Reset state
      #1;
      chk("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("reset_stall", {63'd0, bus.stall_out}, 64'd0);
      edgeAndSettle();
      edgeAndSettle();
      chk("reset_hold_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("reset_hold_op", {58'd0, bus.op_code}, 64'd0);
      rst = 1'b0;

      // Table vectors through the scoreboard
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, vecs[i].instr, 1'b0, vecs[i].wr, vecs[i].wReg, vecs[i].wData);
         sbq.push_back(vecs[i]);
         #1;
         chk($sformatf("vec%0d_stall", i), {63'd0, bus.stall_out}, 64'd0);
         edgeAndSettle();
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL vec%0d_scoreboard_empty", i);
         end else begin
            e = sbq.pop_front();
            chk($sformatf("vec%0d_out_valid", i), {63'd0, bus.out_valid}, 64'd1);
            chk($sformatf("vec%0d_op", i), {58'd0, bus.op_code}, {58'd0, e.op});
            chk($sformatf("vec%0d_funct", i), {58'd0, bus.funct}, {58'd0, e.funct});
            chk($sformatf("vec%0d_rs", i), {59'd0, bus.rs}, {59'd0, e.rs});
            chk($sformatf("vec%0d_rt", i), {59'd0, bus.rt}, {59'd0, e.rt});
            chk($sformatf("vec%0d_rd", i), {59'd0, bus.rd}, {59'd0, e.rd});
            chk($sformatf("vec%0d_rd1", i), {32'd0, bus.read_data1}, {32'd0, e.rd1});
            chk($sformatf("vec%0d_rd2", i), {32'd0, bus.read_data2}, {32'd0, e.rd2});
            chk($sformatf("vec%0d_imm", i), {32'd0, bus.sign_ext_imm}, {32'd0, e.imm});
            chk($sformatf("vec%0d_mem_read", i), {63'd0, bus.mem_read}, {63'd0, e.memRead});
         end
      end

      // Load-use on rs: one-cycle stall, bubble, then consumer sees writeback made during the stall
      drive(1'b1, mk(6'h23, 5'd0, 5'd8, 16'h0), 1'b0, 1'b0, 5'd0, 32'h0);
      edgeAndSettle();
      chk("lw8_mem_read", {63'd0, bus.mem_read}, 64'd1);
      chk("lw8_rt", {59'd0, bus.rt}, 64'd8);
      drive(1'b1, mk(6'h00, 5'd8, 5'd3, 16'h0), 1'b0, 1'b1, 5'd8, 32'h0BADF00D);
      #1;
      chk("lu_stall", {63'd0, bus.stall_out}, 64'd1);
      edgeAndSettle();
      chk("lu_bubble_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("lu_bubble_mem_read", {63'd0, bus.mem_read}, 64'd0);
      chk("lu_bubble_rd1", {32'd0, bus.read_data1}, 64'd0);
      chk("lu_bubble_rs", {59'd0, bus.rs}, 64'd0);
      bus.reg_write = 1'b0;
      #1;
      chk("lu_stall_cleared", {63'd0, bus.stall_out}, 64'd0);
      edgeAndSettle();
      chk("lu_accept_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("lu_accept_rs", {59'd0, bus.rs}, 64'd8);
      chk("lu_accept_rd1", {32'd0, bus.read_data1}, 64'h0BADF00D);

      // lw to r0 never stalls
      drive(1'b1, mk(6'h23, 5'd0, 5'd0, 16'h0), 1'b0, 1'b0, 5'd0, 32'h0);
      edgeAndSettle();
      drive(1'b1, mk(6'h00, 5'd0, 5'd0, 16'h0), 1'b0, 1'b0, 5'd0, 32'h0);
      #1;
      chk("lw_r0_no_stall", {63'd0, bus.stall_out}, 64'd0);
      edgeAndSettle();
      chk("lw_r0_next_valid", {63'd0, bus.out_valid}, 64'd1);

      // Hazard on rt, then flush in the same cycle overrides it
      drive(1'b1, mk(6'h23, 5'd0, 5'd9, 16'h0), 1'b0, 1'b0, 5'd0, 32'h0);
      edgeAndSettle();
      drive(1'b1, mk(6'h00, 5'd3, 5'd9, 16'h0), 1'b0, 1'b0, 5'd0, 32'h0);
      #1;
      chk("rt_hazard_stall", {63'd0, bus.stall_out}, 64'd1);
      bus.flush = 1'b1;
      #1;
      chk("flush_stall", {63'd0, bus.stall_out}, 64'd0);
      edgeAndSettle();
      chk("flush_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("flush_mem_read", {63'd0, bus.mem_read}, 64'd0);
      chk("flush_rt", {59'd0, bus.rt}, 64'd0);

      // Async reset mid-stream clears outputs and the register file
      drive(1'b1, mk(6'h00, 5'd5, 5'd2, 16'h0042), 1'b0, 1'b0, 5'd0, 32'h0);
      edgeAndSettle();
      chk("pre_rst_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("pre_rst_rd1", {32'd0, bus.read_data1}, 64'h11112222);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("async_rst_rd1", {32'd0, bus.read_data1}, 64'd0);
      chk("async_rst_imm", {32'd0, bus.sign_ext_imm}, 64'd0);
      chk("async_rst_stall", {63'd0, bus.stall_out}, 64'd0);
      edgeAndSettle();
      rst = 1'b0;
      edgeAndSettle();
      chk("post_rst_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("post_rst_rd1", {32'd0, bus.read_data1}, 64'd0);
      chk("post_rst_rd2", {32'd0, bus.read_data2}, 64'd0);
      chk("post_rst_imm", {32'd0, bus.sign_ext_imm}, 64'h42);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);

      // 8 x 16 configuration: r9 aliases r1, 16-bit immediate passes through
      bus16.reg_write  = 1'b1;
      bus16.write_reg  = 5'd9;
      bus16.write_data = 16'h5A5A;
      edgeAndSettle();
      bus16.reg_write   = 1'b0;
      bus16.in_valid    = 1'b1;
      bus16.instruction = mk(6'h00, 5'd1, 5'd9, 16'h8001);
      edgeAndSettle();
      chk("p16_valid", {63'd0, bus16.out_valid}, 64'd1);
      chk("p16_rd1_r1", {48'd0, bus16.read_data1}, 64'h5A5A);
      chk("p16_rd2_r9", {48'd0, bus16.read_data2}, 64'h5A5A);
      chk("p16_imm", {48'd0, bus16.sign_ext_imm}, 64'h8001);
      bus16.in_valid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameter DATA_W, default 32, register, read-data and immediate width; legal range 16..64.
REQ-002 Parameter NUM_REGS, default 32, register count; power of two, 2..32; ADDR_W = clog2(NUM_REGS).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 in_valid  in  1  instruction from fetch is valid.
REQ-006 instruction  in  32  MIPS word: op[31:26] rs[25:21] rt[20:16] rd[15:11] funct[5:0] imm[15:0].
REQ-007 flush  in  1  squash the instruction entering ID/EX (taken branch).
REQ-008 reg_write  in  1  writeback enable.
REQ-009 write_reg  in  5  writeback register; only low ADDR_W bits used.
REQ-010 write_data  in  DATA_W  writeback data.
REQ-011 stall_out  out  1  load-use hazard; fetch holds PC and instruction.
REQ-012 out_valid  out  1  ID/EX contents valid.
REQ-013 op_code, funct  out  6 each  registered opcode and function fields.
REQ-014 rs, rt, rd  out  5 each  registered register fields.
REQ-015 read_data1, read_data2  out  DATA_W  registered rs/rt operands.
REQ-016 sign_ext_imm  out  DATA_W  registered sign-extended imm.
REQ-017 mem_read  out  1  registered; 1 when op_code = 6'b100011 (lw).

Function
REQ-018 Register file: NUM_REGS x DATA_W; index = field[ADDR_W-1:0]; register 0 always reads 0.
REQ-019 Write on rising clk when reg_write=1 and write_reg[ADDR_W-1:0] != 0; writes to register 0 are discarded.
REQ-020 Reads combinational with write-first bypass: same-cycle writeback to the read index (non-zero) returns write_data.
REQ-021 Immediate: instruction[15] replicated into bits DATA_W-1..16.
REQ-022 Latency 1: fields/operands of a cycle-N accepted instruction appear on outputs after edge N.
REQ-023 stall_out = in_valid & out_valid & mem_read & (rt != 0) & (rt == instruction[25:21] | rt == instruction[20:16]) & ~flush; combinational.
REQ-024 Next out_valid = in_valid & ~stall_out & ~flush.
REQ-025 Bubble (next out_valid=0): all ID/EX datapath outputs and mem_read load 0.
REQ-026 flush takes priority over stall and in_valid; flush+stall in same cycle -> bubble, stall_out=0.
REQ-027 A stall lasts exactly one cycle per hazard: bubble clears mem_read, so the held instruction is accepted next cycle.
REQ-028 Simultaneous writeback and hazard: bypassed data captured only when the instruction is accepted, never during the bubble.

Reset
REQ-029 rst=1 immediately clears all ID/EX outputs, out_valid and mem_read to 0, and every register-file entry to 0.
REQ-030 stall_out=0 while rst=1; first instruction is accepted on the first rising edge after rst deasserts.

Verification
REQ-031 Reset, then in_valid=1, instruction=0x04430004 -> next cycle op_code=1, rs=2, rt=3, sign_ext_imm=4, out_valid=1, read_data=0.
REQ-032 reg_write=1, write_reg=5, write_data=0xDEADBEEF while instruction reads rs=5 -> read_data1=0xDEADBEEF next cycle (bypass); write_reg=0 -> r0 still 0.
REQ-033 imm=0x8000, DATA_W=32 -> sign_ext_imm=0xFFFF8000; imm=0x7FFF -> 0x00007FFF.
REQ-034 lw rt=8 accepted, next instruction rs=8 -> stall_out=1 one cycle, out_valid=0 bubble, then consumer accepted with out_valid=1; lw rt=0 -> no stall.
REQ-035 flush=1 with hazard pending -> stall_out=0, out_valid=0 next cycle; rst asserted mid-stream -> outputs 0 without clock edge.
REQ-036 NUM_REGS=8, DATA_W=16: write r9 lands in r1; immediate 0x8001 -> 0x8001.
